ysyx_22041207_rd_arbiter: RTL

Two-master read arbiter sharing the single AXI-style memory read port between instruction fetch (master 0, IF) and load/store (master 1, LSU). Sits between the IF/MEM stages and the memory/AXI bridge. Grants one whole read transaction at a time: address phase, then data phase, then release. Masters and slave use the same valid/ready address and data handshakes as the IF fetch port.

---
 rtl/ysyx_22041207_pkg.sv | 17 +
 rtl/ysyx_22041207_arb_pick.sv | 23 ++
 rtl/ysyx_22041207_rd_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/ysyx_22041207_pkg.sv
// Shared types and constants for the ysyx_22041207 read arbiter.
package ysyx_22041207_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int SIZE_W = 8;

    localparam logic GRANT_IF  = 1'b0;
    localparam logic GRANT_LSU = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ysyx_22041207_arb_pick.sv
// Combinational two-way picker: a lone requester wins; a tie goes to the
// master that is not last_grant.
module ysyx_22041207_arb_pick
    import ysyx_22041207_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic winner,
    output logic any
);

    always_comb begin
        any    = valid0 | valid1;
        winner = GRANT_IF;
        if (valid0 && valid1) begin
            winner = ~last_grant;
        end else if (valid1) begin
            winner = GRANT_LSU;
        end
    end

endmodule

// File: rtl/ysyx_22041207_rd_arbiter.sv
// Two-master read arbiter (IF = m0, LSU = m1) in front of one memory read port.
// Define YSYX_22041207_ARB_RR_EN for round-robin ties; otherwise LSU wins ties.
module ysyx_22041207_rd_arbiter
    import ysyx_22041207_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_r_valid_i,
    output logic              m0_r_ready_o,
    input  logic [ADDR_W-1:0] m0_r_addr_i,
    input  logic [SIZE_W-1:0] m0_r_size_i,
    output logic              m0_data_valid_o,
    input  logic              m0_data_ready_i,
    output logic [DATA_W-1:0] m0_data_o,

    input  logic              m1_r_valid_i,
    output logic              m1_r_ready_o,
    input  logic [ADDR_W-1:0] m1_r_addr_i,
    input  logic [SIZE_W-1:0] m1_r_size_i,
    output logic              m1_data_valid_o,
    input  logic              m1_data_ready_i,
    output logic [DATA_W-1:0] m1_data_o,

    output logic              s_r_valid_o,
    input  logic              s_r_ready_i,
    output logic [ADDR_W-1:0] s_r_addr_o,
    output logic [SIZE_W-1:0] s_r_size_o,
    input  logic              s_data_valid_i,
    output logic              s_data_ready_o,
    input  logic [DATA_W-1:0] s_data_i,

    output logic              grant_o,
    output logic              busy_o
);

    arb_state_e state;
    logic       last_grant;
    logic       pick_winner;
    logic       pick_any;
    logic       in_idle;
    logic       in_data;
    logic       accept;
    logic       data_done;

    ysyx_22041207_arb_pick u_pick (
        .valid0     (m0_r_valid_i),
        .valid1     (m1_r_valid_i),
        .last_grant (last_grant),
        .winner     (pick_winner),
        .any        (pick_any)
    );

    assign in_idle   = (state == IDLE);
    assign in_data   = (state == DATA);
    assign accept    = in_idle && pick_any;
    assign data_done = s_data_valid_i && s_data_ready_o;

`ifdef YSYX_22041207_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GRANT_IF;
        end else if (accept) begin
            last_grant <= pick_winner;
        end
    end
`else
    // Pinning last_grant to IF turns the picker's tie rule into fixed LSU priority.
    assign last_grant = GRANT_IF;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_o    <= GRANT_IF;
            s_r_addr_o <= '0;
            s_r_size_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_o    <= pick_winner;
                        s_r_addr_o <= (pick_winner == GRANT_LSU) ? m1_r_addr_i : m0_r_addr_i;
                        s_r_size_o <= (pick_winner == GRANT_LSU) ? m1_r_size_i : m0_r_size_i;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (s_r_ready_i) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (data_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request acceptance is combinational so a master is handshaken the cycle it asks.
    assign m0_r_ready_o = accept && (pick_winner == GRANT_IF);
    assign m1_r_ready_o = accept && (pick_winner == GRANT_LSU);

    assign s_r_valid_o    = (state == ADDR);
    assign s_data_ready_o = in_data && ((grant_o == GRANT_LSU) ? m1_data_ready_i : m0_data_ready_i);

    assign m0_data_valid_o = in_data && (grant_o == GRANT_IF)  && s_data_valid_i;
    assign m1_data_valid_o = in_data && (grant_o == GRANT_LSU) && s_data_valid_i;
    assign m0_data_o       = s_data_i;
    assign m1_data_o       = s_data_i;

    assign busy_o = !in_idle;

endmodule
